// File: rtl/types_pkg.sv
// Shared types for the reservation station: renamed µop, RS entry and ROB-age helper.
package types_pkg;

    localparam int NPREG_DEF     = 128;
    localparam int ROB_DEPTH_DEF = 16;
    localparam int PREG_W        = $clog2(NPREG_DEF);
    localparam int ROB_W         = $clog2(ROB_DEPTH_DEF) + 1;
    localparam int AGE_W         = ROB_W - 1;
    localparam int OP_W          = 8;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [PREG_W-1:0] pdst;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
    } rename_data;

    typedef struct packed {
        rename_data        uop;
        logic [ROB_W-1:0]  rob_index;
        logic              ps1_ready;
        logic              ps2_ready;
        logic              ready;
    } rs_data;

    // Distance from the ROB head; the tag MSB is a wrap bit and drops out here.
    function automatic logic [AGE_W-1:0] age_of(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] diff;
        diff = tag - head;
        return diff[AGE_W-1:0];
    endfunction

endpackage

// File: rtl/res_station_age_if.sv
// Dispatch and issue handshakes between rename, the reservation station and the FU.
interface res_station_age_if;
    import types_pkg::*;

    rename_data       r_data;
    logic             di_valid;
    logic             di_ready;
    logic [ROB_W-1:0] rob_index_in;
    logic             issue_valid;
    logic             issue_ready;
    rs_data           issue_data;

    modport master (
        output r_data, di_valid, rob_index_in, issue_ready,
        input  di_ready, issue_valid, issue_data
    );

    modport slave (
        input  r_data, di_valid, rob_index_in, issue_ready,
        output di_ready, issue_valid, issue_data
    );

endinterface

// File: rtl/rs_age_select.sv
// Combinational oldest-first picker: one-hot grant to the requesting entry with the smallest age.
module rs_age_select #(
    parameter int DEPTH    = 8,
    parameter int AGE_BITS = 4
) (
    input  logic [DEPTH-1:0]                req,
    input  logic [DEPTH-1:0][AGE_BITS-1:0]  age,
    output logic [DEPTH-1:0]                grant,
    output logic                            found
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]    best_idx;
    logic [AGE_BITS-1:0] best_age;

    // Strict less-than keeps the lower index on an age tie.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!found || (age[i] < best_age))) begin
                found    = 1'b1;
                best_idx = IDX_W'(i);
                best_age = age[i];
            end
        end
        grant = '0;
        if (found) begin
            grant[best_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/res_station_age.sv
// Reservation station between dispatch and one FU: operand wakeup, oldest-ready issue
// into a registered output stage, and flush of entries younger than a mispredicted branch.
module res_station_age
    import types_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int NPREG     = 128,
    parameter int ROB_DEPTH = 16,
    parameter int WB_PORTS  = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    res_station_age_if.slave                  rs_if,
    input  logic [0:NPREG-1]                  preg_rtable,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS-1:0][PREG_W-1:0]   wb_tag,
    input  logic [ROB_W-1:0]                  rob_head,
    input  logic                              mispredict,
    input  logic [ROB_W-1:0]                  mispredict_tag,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = IDX_W + 1;
    localparam int AGE_BITS = $clog2(ROB_DEPTH);

    rs_data                            entries [DEPTH];
    logic   [DEPTH-1:0]                valid;
    logic   [DEPTH-1:0]                ps1_next;
    logic   [DEPTH-1:0]                ps2_next;
    logic   [DEPTH-1:0]                flush_kill;
    logic   [DEPTH-1:0]                cand_req;
    logic   [DEPTH-1:0]                grant;
    logic   [DEPTH-1:0][AGE_BITS-1:0]  ages;
    logic   [AGE_BITS-1:0]             branch_age;
    logic   [AGE_BITS-1:0]             held_age;
    logic   [IDX_W-1:0]                alloc_idx;
    logic                              has_free;
    logic                              found;
    logic                              load;
    logic                              dispatch_fire;
    logic                              held_young;
    logic                              issue_valid_q;
    rs_data                            issue_data_q;
    rs_data                            cand;
    rs_data                            new_entry;

    function automatic logic src_hit(input logic [0:NPREG-1]                rt,
                                     input logic [WB_PORTS-1:0]             wv,
                                     input logic [WB_PORTS-1:0][PREG_W-1:0] wt,
                                     input logic [PREG_W-1:0]               ps);
        logic hit;
        hit = rt[ps];
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wv[k] && (wt[k] == ps)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        branch_age = AGE_BITS'(age_of(mispredict_tag, rob_head));
        held_age   = AGE_BITS'(age_of(issue_data_q.rob_index, rob_head));
        for (int i = 0; i < DEPTH; i++) begin
            ages[i]       = AGE_BITS'(age_of(entries[i].rob_index, rob_head));
            flush_kill[i] = mispredict && valid[i] && (ages[i] > branch_age);
            cand_req[i]   = valid[i] && entries[i].ready && !flush_kill[i];
            ps1_next[i]   = entries[i].ps1_ready ||
                            src_hit(preg_rtable, wb_valid, wb_tag, entries[i].uop.ps1);
            ps2_next[i]   = entries[i].ps2_ready ||
                            src_hit(preg_rtable, wb_valid, wb_tag, entries[i].uop.ps2);
        end
    end

    // Lowest-index free slot, taken from registered occupancy only.
    always_comb begin
        alloc_idx = '0;
        has_free  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
                has_free  = 1'b1;
            end
        end
    end

    always_comb begin
        new_entry           = '0;
        new_entry.uop       = rs_if.r_data;
        new_entry.rob_index = rs_if.rob_index_in;
        new_entry.ps1_ready = src_hit(preg_rtable, wb_valid, wb_tag, rs_if.r_data.ps1);
        new_entry.ps2_ready = src_hit(preg_rtable, wb_valid, wb_tag, rs_if.r_data.ps2);
        new_entry.ready     = new_entry.ps1_ready && new_entry.ps2_ready;
    end

    rs_age_select #(
        .DEPTH    (DEPTH),
        .AGE_BITS (AGE_BITS)
    ) u_select (
        .req   (cand_req),
        .age   (ages),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                cand = entries[i];
            end
        end
    end

    // A dispatch during a flush is always younger than the branch, so it is dropped.
    assign dispatch_fire = rs_if.di_valid && has_free && !mispredict;
    assign load          = (!issue_valid_q || rs_if.issue_ready) && found;
    assign held_young    = mispredict && issue_valid_q && (held_age > branch_age);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((load && grant[i]) || flush_kill[i]) begin
                    valid[i] <= 1'b0;
                end else if (valid[i]) begin
                    entries[i].ps1_ready <= ps1_next[i];
                    entries[i].ps2_ready <= ps2_next[i];
                    entries[i].ready     <= ps1_next[i] && ps2_next[i];
                end
            end
            if (dispatch_fire) begin
                valid[alloc_idx]   <= 1'b1;
                entries[alloc_idx] <= new_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else if (load) begin
            issue_valid_q <= 1'b1;
            issue_data_q  <= cand;
        end else if (rs_if.issue_ready || held_young) begin
            issue_valid_q <= 1'b0;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid[i]);
        end
    end

    assign rs_if.di_ready    = has_free;
    assign rs_if.issue_valid = issue_valid_q;
    assign rs_if.issue_data  = issue_data_q;

endmodule

// File: tb/tb_res_station_age.sv
// Randomized scoreboard bench for res_station_age against a queue-based reference model.
module tb_res_station_age;
    import types_pkg::*;

    localparam int DEPTH     = 8;
    localparam int NPREG     = 128;
    localparam int ROB_DEPTH = 16;
    localparam int WB_PORTS  = 2;

    logic                            clk = 1'b0;
    logic                            reset_n;
    logic [0:NPREG-1]                preg_rtable;
    logic [WB_PORTS-1:0]             wb_valid;
    logic [WB_PORTS-1:0][PREG_W-1:0] wb_tag;
    logic [ROB_W-1:0]                rob_head;
    logic                            mispredict;
    logic [ROB_W-1:0]                mispredict_tag;
    logic [$clog2(DEPTH):0]          count;

    always #5 clk = ~clk;

    res_station_age_if rs_if ();

    res_station_age #(
        .DEPTH     (DEPTH),
        .NPREG     (NPREG),
        .ROB_DEPTH (ROB_DEPTH),
        .WB_PORTS  (WB_PORTS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rs_if          (rs_if),
        .preg_rtable    (preg_rtable),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .count          (count)
    );

    typedef struct {
        int tag;
        int op;
        int pdst;
        int ps1;
        int ps2;
        bit r1;
        bit r2;
        bit rdy;
    } m_entry_t;

    typedef struct {
        bit iv;
        int cnt;
        bit dir;
    } state_exp_t;

    m_entry_t   model_q[$];
    m_entry_t   m_issue;
    bit         m_iv;
    int         next_tag;
    state_exp_t state_q[$];
    m_entry_t   issue_exp_q[$];
    int         checks;
    int         errors;
    bit         monitor_on;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_age(input int t, input int h);
        return (t - h + 32) % ROB_DEPTH;
    endfunction

    function automatic bit model_hit(input int p);
        if (preg_rtable[p]) return 1'b1;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && (int'(wb_tag[k]) == p)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Oldest outstanding tag is the farthest behind the next tag to be allocated.
    function automatic int oldest_tag();
        int best;
        int best_d;
        int d;
        best   = next_tag;
        best_d = 0;
        foreach (model_q[i]) begin
            d = (next_tag - model_q[i].tag + 32) % 32;
            if (d > best_d) begin
                best_d = d;
                best   = model_q[i].tag;
            end
        end
        if (m_iv) begin
            d = (next_tag - m_issue.tag + 32) % 32;
            if (d > best_d) best = m_issue.tag;
        end
        return best;
    endfunction

    task automatic drive_idle();
        rs_if.di_valid     = 1'b0;
        rs_if.r_data       = '0;
        rs_if.rob_index_in = '0;
        rs_if.issue_ready  = 1'b0;
        preg_rtable        = '0;
        wb_valid           = '0;
        wb_tag             = '0;
        rob_head           = '0;
        mispredict         = 1'b0;
        mispredict_tag     = '0;
    endtask

    // Modes: 0 random, 1 ready dispatch, 2 unready fill, 3 drain, 4 ready dispatch under backpressure.
    task automatic applyStimulus(input int mode);
        bit         dv;
        bit         ir;
        bit         mp;
        bit         disp;
        bit         can_load;
        int         mpt;
        int         head;
        int         ba;
        int         ci;
        int         tags[$];
        rename_data rd;
        m_entry_t   e;

        @(negedge clk);
        head = oldest_tag();
        dv   = (mode == 1 || mode == 2 || mode == 4) ? 1'b1
             : (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
        if (((next_tag - head + 32) % 32) >= 14) dv = 1'b0;
        rd.op   = OP_W'($urandom);
        rd.pdst = PREG_W'($urandom_range(0, NPREG - 1));
        rd.ps1  = PREG_W'($urandom_range(0, 15));
        rd.ps2  = PREG_W'($urandom_range(0, 15));
        for (int p = 0; p < NPREG; p++) begin
            preg_rtable[p] = (mode == 0) ? ($urandom_range(0, 99) < 8) : (mode != 2);
        end
        for (int k = 0; k < WB_PORTS; k++) begin
            wb_valid[k] = (mode == 0) && ($urandom_range(0, 1) == 1);
            wb_tag[k]   = PREG_W'($urandom_range(0, 15));
        end
        ir  = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode != 4);
        mp  = 1'b0;
        mpt = 0;
        if (mode == 0 && $urandom_range(0, 9) == 0) begin
            foreach (model_q[i]) tags.push_back(model_q[i].tag);
            if (m_iv) tags.push_back(m_issue.tag);
            if (tags.size() > 0) begin
                mp  = 1'b1;
                mpt = tags[$urandom_range(0, tags.size() - 1)];
            end
        end

        state_q.push_back('{m_iv, model_q.size(), model_q.size() < DEPTH});
        if (m_iv && ir) issue_exp_q.push_back(m_issue);

        rs_if.di_valid     = dv;
        rs_if.r_data       = rd;
        rs_if.rob_index_in = ROB_W'(next_tag);
        rs_if.issue_ready  = ir;
        rob_head           = ROB_W'(head);
        mispredict         = mp;
        mispredict_tag     = ROB_W'(mpt);

        disp = dv && (model_q.size() < DEPTH) && !mp;
        ba   = model_age(mpt, head);
        if (mp) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_age(model_q[i].tag, head) > ba) model_q.delete(i);
            end
        end
        ci = -1;
        foreach (model_q[i]) begin
            if (model_q[i].rdy &&
                (ci < 0 || model_age(model_q[i].tag, head) < model_age(model_q[ci].tag, head)))
                ci = i;
        end
        can_load = !m_iv || ir;
        if (can_load && ci >= 0) begin
            m_issue = model_q[ci];
            m_iv    = 1'b1;
            model_q.delete(ci);
        end else if (ir) begin
            m_iv = 1'b0;
        end else if (mp && m_iv && model_age(m_issue.tag, head) > ba) begin
            m_iv = 1'b0;
        end
        foreach (model_q[i]) begin
            model_q[i].r1  = model_q[i].r1 || model_hit(model_q[i].ps1);
            model_q[i].r2  = model_q[i].r2 || model_hit(model_q[i].ps2);
            model_q[i].rdy = model_q[i].r1 && model_q[i].r2;
        end
        if (disp) begin
            e.tag  = next_tag;
            e.op   = int'(rd.op);
            e.pdst = int'(rd.pdst);
            e.ps1  = int'(rd.ps1);
            e.ps2  = int'(rd.ps2);
            e.r1   = model_hit(e.ps1);
            e.r2   = model_hit(e.ps2);
            e.rdy  = e.r1 && e.r2;
            model_q.push_back(e);
            next_tag = (next_tag + 1) % 32;
        end
        if (mp) next_tag = (mpt + 1) % 32;
    endtask

    task automatic checkOutput();
        state_exp_t s;
        m_entry_t   e;
        if (state_q.size() == 0) begin
            check_val("state_queue_empty", 0, 1);
        end else begin
            s = state_q.pop_front();
            check_val("issue_valid", int'(rs_if.issue_valid), int'(s.iv));
            check_val("count", int'(count), s.cnt);
            check_val("di_ready", int'(rs_if.di_ready), int'(s.dir));
        end
        if (rs_if.issue_valid && rs_if.issue_ready) begin
            if (issue_exp_q.size() == 0) begin
                check_val("unexpected_issue_tag", int'(rs_if.issue_data.rob_index), -1);
            end else begin
                e = issue_exp_q.pop_front();
                check_val("issue_rob_tag", int'(rs_if.issue_data.rob_index), e.tag);
                check_val("issue_op", int'(rs_if.issue_data.uop.op), e.op);
                check_val("issue_pdst", int'(rs_if.issue_data.uop.pdst), e.pdst);
                check_val("issue_ps1", int'(rs_if.issue_data.uop.ps1), e.ps1);
                check_val("issue_ps2", int'(rs_if.issue_data.uop.ps2), e.ps2);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (monitor_on) checkOutput();
        end
    end

    task automatic run_cycles(input int mode, input int n);
        repeat (n) applyStimulus(mode);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_issue_valid"}, int'(rs_if.issue_valid), 0);
        check_val({tag, "_count"}, int'(count), 0);
        check_val({tag, "_di_ready"}, int'(rs_if.di_ready), 1);
        check_val({tag, "_issue_data_zero"}, int'(rs_if.issue_data == '0), 1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        monitor_on = 1'b0;
        m_iv       = 1'b0;
        next_tag   = 3;
        reset_n    = 1'b0;
        drive_idle();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        monitor_on = 1'b1;

        $display("[TB] ordered ready dispatch, tags 3..10");
        run_cycles(1, 8);
        run_cycles(3, 6);

        $display("[TB] unready fill then random traffic");
        run_cycles(2, 10);
        run_cycles(0, 600);
        run_cycles(3, 12);

        $display("[TB] backpressure then asynchronous reset");
        run_cycles(4, 6);
        #5;
        monitor_on = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_q.delete();
        state_q.delete();
        issue_exp_q.delete();
        m_iv     = 1'b0;
        next_tag = 30;
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        monitor_on = 1'b1;

        $display("[TB] wrapped tags and more random traffic");
        run_cycles(4, 5);
        run_cycles(3, 8);
        run_cycles(0, 800);
        run_cycles(3, 12);
        #3;
        monitor_on = 1'b0;

        check_val("issue_queue_leftover", issue_exp_q.size(), 0);
        check_val("state_queue_leftover", state_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/res_station_age.md
# res_station_age

Parametrised reservation station with oldest-first selection, placed between dispatch and one functional unit. It accepts renamed µops through a valid/ready handshake and wakes operands from the physical-register ready table and from same-cycle writeback broadcasts. It issues the oldest ready entry, judged by ROB age, into a registered output stage held under FU backpressure. On a mispredict it flushes every entry younger than the branch.

## Interface
Parameters:
- DEPTH, 8: number of RS entries (power of two, at least 2)
- NPREG, 128: physical registers; PREG_W = $clog2(NPREG)
- ROB_DEPTH, 16: ROB entries; ROB_W = $clog2(ROB_DEPTH)+1 (5 at default, matching the existing 5-bit ROB tags; the MSB is ignored for age math)
- WB_PORTS, 2: writeback broadcast ports

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- r_data  in  rename_data  renamed µop
- di_valid  in  1  dispatch request
- di_ready  out  1  a free entry exists
- rob_index_in  in  ROB_W  ROB tag of the dispatched µop
- preg_rtable  in  [0:NPREG-1]  physical-register ready bits
- wb_valid  in  WB_PORTS  writeback broadcast valid
- wb_tag  in  WB_PORTS×PREG_W  writeback destination preg
- rob_head  in  ROB_W  oldest ROB tag, used as the age reference
- mispredict  in  1  flush request
- mispredict_tag  in  ROB_W  ROB tag of the mispredicted branch
- issue_valid  out  1  issue_data holds a µop
- issue_ready  in  1  FU accepts issue_data
- issue_data  out  rs_data  issued entry
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Age is defined as age(t) = (t − rob_head) mod ROB_DEPTH; a smaller age means an older µop.
- Dispatch:
  - Fires when di_valid && di_ready.
  - The µop is written into the lowest-index free entry.
  - ps1_ready and ps2_ready are set from preg_rtable[ps] OR any wb_valid[k] with wb_tag[k]==ps.
  - ready = ps1_ready && ps2_ready, stored in the entry.
- Wakeup, every cycle, for each valid entry and each source that is not yet ready:
  - Set the source ready on a preg_rtable hit or a wb tag match.
  - The entry's ready bit is recomputed combinationally from the post-update source bits, so a wakeup makes the entry selectable next cycle.
- Select: among entries that are valid and ready, pick the minimum age. Ties are impossible; if one occurs, the lower index wins.
- Issue stage:
  - When !issue_valid || issue_ready and a candidate exists, load the candidate into issue_data, set issue_valid and free its entry.
  - Otherwise, if issue_ready, clear issue_valid.
  - issue_data is held stable while issue_valid && !issue_ready.
- Flush, when mispredict is asserted:
  - Invalidate every entry with age > age(mispredict_tag).
  - Clear issue_valid if the held µop is younger than the branch.
  - A dispatch in the same cycle is dropped, since it is by construction younger.
  - Select and issue in the same cycle use only surviving entries.
- di_ready = free entry exists, computed from registered state. Entries freed this cycle are not visible until next cycle (no free-to-dispatch bypass).
- count reflects registered occupancy and excludes the issue stage.

## Timing
- Reset (reset_n low, asynchronous): all entries invalid, issue_valid=0, issue_data='0, count=0, di_ready=1. Reset mid-operation discards everything immediately.
- Dispatch to issue_valid: minimum 2 cycles if the µop is ready at dispatch (written at edge N, selected and loaded at edge N+1).
- Wakeup to issue_valid: the entry is selected and loaded at the first edge after the wakeup edge.
- Full: when count==DEPTH, di_ready=0; a di_valid request is held by the producer.
- Simultaneous issue-free and dispatch: the freed slot is not reused until the next cycle.
- Simultaneous writeback and dispatch of a matching source: the source is captured ready.

## Structure
- Extend rs_data in types_pkg with an age-comparison helper function, age_of(tag, head).
- Keep the rename_data and rs_data typedefs in types_pkg.
- One sub-module, rs_age_select: combinational oldest-ready picker over DEPTH entries. Its outputs are a one-hot grant and a found flag.

## Test plan
- Reset, then dispatch 8 ready µops with ROB tags 3..10 and head=3, issue_ready=1 -> issues in tag order 3..10, one per cycle, first issue_valid 2 cycles after the first dispatch.
- Fill 8 entries with unready sources -> di_ready=0, count=8. Then broadcast wb_tag=ps1 of tag 7 (with ps2 already ready) -> tag 7 issues the next cycle.
- Entries at tags 14, 15, 0, 1 (wrapped), all ready, head=14 -> issue order 14, 15, 0, 1.
- mispredict_tag=5, head=2, entries 3, 6, 9 present, dispatch of tag 10 in the same cycle -> only tag 3 remains, count=1, tag 10 not written.
- issue_ready=0 for 3 cycles with issue_valid=1 -> issue_data is stable, the next-oldest ready entry is retained, and it issues the cycle after issue_ready rises.
- Assert reset_n low mid-stream with 5 entries and issue_valid=1 -> outputs zero immediately (asynchronous), count=0, di_ready=1.
